// File: rtl/led_pattern_gen_if.sv
// Control and display bundle for led_pattern_gen.
// The brightness signal exists only when LED_PWM_EN is defined.
interface led_pattern_gen_if #(
    parameter int unsigned LED_W = 8
);
    logic [1:0]       mode;
    logic [1:0]       speed;
    logic             pause;
    logic             step;
`ifdef LED_PWM_EN
    logic [3:0]       brightness;
`endif
    logic [LED_W-1:0] led;
    logic             tick;

`ifdef LED_PWM_EN
    modport master (output mode, speed, pause, step, brightness, input led, tick);
    modport slave  (input mode, speed, pause, step, brightness, output led, tick);
`else
    modport master (output mode, speed, pause, step, input led, tick);
    modport slave  (input mode, speed, pause, step, output led, tick);
`endif
endinterface

// File: rtl/led_pattern_gen.sv
// Prescaled LED pattern generator: up / down / rotate / bounce with pause and single-step.
// Define LED_PWM_EN to add a registered PWM brightness stage on the LED outputs.
module led_pattern_gen #(
    parameter int unsigned CLK_HZ  = 50000000,
    parameter int unsigned TICK_HZ = 1,
    parameter int unsigned LED_W   = 8,
    parameter int unsigned PWM_DIV = 256
) (
    input logic              CLK50MHZ,
    input logic              reset,
    led_pattern_gen_if.slave bus
);
    typedef enum logic [1:0] {ModeUp, ModeDown, ModeRotate, ModeBounce} mode_e;
    typedef enum logic {DirLeft, DirRight} dir_e;

    localparam logic [31:0] BaseDiv = 32'(CLK_HZ / TICK_HZ);

    if (LED_W < 2 || PWM_DIV < 1) begin : g_param_check
        $error("led_pattern_gen: LED_W must be >= 2 and PWM_DIV >= 1");
    end

    logic [31:0]      cnt_q, cnt_d;
    logic [LED_W-1:0] pat_q, pat_d;
    dir_e             dir_q, dir_d;
    mode_e            mode_q, mode_d;
    logic             tick_q, tick_d;

    logic [31:0]      period;
    logic             at_end;
    logic             adv;
    logic [LED_W-1:0] pat_nxt;
    dir_e             dir_nxt;

    always_comb begin
        period = BaseDiv >> bus.speed;
        if (period == 32'd0) begin
            period = 32'd1;
        end
        // ">=" also catches a count left beyond the end by a speed increase.
        at_end = cnt_q >= (period - 32'd1);
        adv    = bus.pause ? bus.step : at_end;

        pat_nxt = pat_q;
        dir_nxt = dir_q;
        unique case (mode_q)
            ModeUp:     pat_nxt = pat_q + 1'b1;
            ModeDown:   pat_nxt = pat_q - 1'b1;
            ModeRotate: pat_nxt = {pat_q[LED_W-2:0], pat_q[LED_W-1]};
            ModeBounce: begin
                if (dir_q == DirLeft) begin
                    if (pat_q[LED_W-1]) begin
                        dir_nxt = DirRight;
                        pat_nxt = pat_q >> 1;
                    end else begin
                        pat_nxt = pat_q << 1;
                    end
                end else begin
                    if (pat_q[0]) begin
                        dir_nxt = DirLeft;
                        pat_nxt = pat_q << 1;
                    end else begin
                        pat_nxt = pat_q >> 1;
                    end
                end
            end
            default: pat_nxt = pat_q;
        endcase
    end

    always_comb begin
        cnt_d  = cnt_q;
        pat_d  = pat_q;
        dir_d  = dir_q;
        mode_d = mode_q;
        tick_d = 1'b0;
        if (bus.mode != mode_q) begin
            // Seed load wins over any advance on the same edge.
            mode_d = mode_e'(bus.mode);
            cnt_d  = 32'd0;
            dir_d  = DirLeft;
            unique case (mode_e'(bus.mode))
                ModeUp:   pat_d = '0;
                ModeDown: pat_d = '1;
                default:  pat_d = {{(LED_W-1){1'b0}}, 1'b1};
            endcase
        end else begin
            if (!bus.pause) begin
                cnt_d = at_end ? 32'd0 : cnt_q + 32'd1;
            end
            if (adv) begin
                pat_d  = pat_nxt;
                dir_d  = dir_nxt;
                tick_d = 1'b1;
            end
        end
    end

    always_ff @(posedge CLK50MHZ) begin
        if (reset) begin
            cnt_q  <= 32'd0;
            pat_q  <= '1;
            dir_q  <= DirLeft;
            mode_q <= mode_e'(bus.mode);
            tick_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            pat_q  <= pat_d;
            dir_q  <= dir_d;
            mode_q <= mode_d;
            tick_q <= tick_d;
        end
    end

    assign bus.tick = tick_q;

`ifdef LED_PWM_EN
    logic [31:0]      div_q;
    logic [3:0]       pwm_cnt_q;
    logic             pwm_on;
    logic [LED_W-1:0] led_q;

    assign pwm_on = (bus.brightness == 4'd15) | (pwm_cnt_q < bus.brightness);

    always_ff @(posedge CLK50MHZ) begin
        if (reset) begin
            div_q     <= 32'd0;
            pwm_cnt_q <= 4'd0;
            led_q     <= '1;
        end else begin
            if (div_q >= 32'(PWM_DIV - 1)) begin
                div_q     <= 32'd0;
                pwm_cnt_q <= pwm_cnt_q + 4'd1;
            end else begin
                div_q <= div_q + 32'd1;
            end
            led_q <= pat_q & {LED_W{pwm_on}};
        end
    end

    assign bus.led = led_q;
`else
    assign bus.led = pat_q;
`endif
endmodule

// File: tb/tb_led_pattern_gen.sv
// Randomised scoreboard bench for led_pattern_gen (CLK_HZ=16, TICK_HZ=1, LED_W=8).
// A reference model predicts each load/step event; a negedge monitor checks the DUT against it.
module tb_led_pattern_gen;
    localparam int unsigned LedW = 8;

    typedef struct {
        int         cyc;
        logic [7:0] led;
        logic       tick;
    } ev_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   total = 0;
    int   bad = 0;
    ev_t  exp_q[$];

    // Reference state: displayed value, unpaused clocks since last step, latched mode,
    // and position within the 14-value bounce cycle.
    int m_pat = 255;
    int m_el = 0;
    int m_mq = 1;
    int m_bidx = 0;

    led_pattern_gen_if #(.LED_W(LedW)) ifc ();

    led_pattern_gen #(
        .CLK_HZ (16),
        .TICK_HZ(1),
        .LED_W  (LedW),
        .PWM_DIV(1)
    ) dut (
        .CLK50MHZ(clk),
        .reset   (rst),
        .bus     (ifc.slave)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic int bounce_val(input int idx);
        return (idx <= 7) ? (1 << idx) : (1 << (14 - idx));
    endfunction

    task automatic model(input bit r, input int md, input int sp, input bit ps, input bit st);
        int  p;
        bit  adv;
        ev_t e;
        p = 16 >> sp;
        if (p < 1) p = 1;
        e.cyc  = cyc + 1;
        e.tick = 1'b0;
        if (r) begin
            m_pat = 255; m_el = 0; m_mq = md; m_bidx = 0;
            e.led = 8'hFF;
            exp_q.push_back(e);
        end else if (md != m_mq) begin
            m_mq = md; m_el = 0; m_bidx = 0;
            m_pat = (md == 0) ? 0 : (md == 1) ? 255 : 1;
            e.led = 8'(m_pat);
            exp_q.push_back(e);
        end else begin
            adv = ps ? st : (m_el >= p - 1);
            if (!ps) m_el = (m_el >= p - 1) ? 0 : m_el + 1;
            if (adv) begin
                case (m_mq)
                    0: m_pat = (m_pat + 1) % 256;
                    1: m_pat = (m_pat + 255) % 256;
                    2: m_pat = ((m_pat * 2) % 256) + (m_pat / 128);
                    default: begin
                        m_bidx = (m_bidx + 1) % 14;
                        m_pat  = bounce_val(m_bidx);
                    end
                endcase
                e.led  = 8'(m_pat);
                e.tick = 1'b1;
                exp_q.push_back(e);
            end
        end
    endtask

    task automatic drive(input bit r, input int md, input int sp, input bit ps, input bit st);
        rst       = r;
        ifc.mode  = 2'(md);
        ifc.speed = 2'(sp);
        ifc.pause = ps;
        ifc.step  = st;
        model(r, md, sp, ps, st);
        @(posedge clk);
        #1;
    endtask

    task automatic run(input int n, input int md, input int sp, input bit ps);
        for (int i = 0; i < n; i++) drive(1'b0, md, sp, ps, 1'b0);
    endtask

    // Monitor: pop an expectation on its cycle, otherwise require a held led and no tick.
    initial begin
        ev_t        e;
        bit         have_last;
        logic [7:0] last_led;
        have_last = 1'b0;
        last_led  = 8'h00;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
                e = exp_q.pop_front();
                total++;
                if (ifc.led !== e.led || ifc.tick !== e.tick) begin
                    bad++;
                    $display("FAIL event cyc=%0d: led=%h tick=%b, required led=%h tick=%b",
                             cyc, ifc.led, ifc.tick, e.led, e.tick);
                end
                last_led  = e.led;
                have_last = 1'b1;
            end else if (have_last) begin
                total++;
                if (ifc.led !== last_led || ifc.tick !== 1'b0) begin
                    bad++;
                    $display("FAIL hold cyc=%0d: led=%h tick=%b, required led=%h tick=0",
                             cyc, ifc.led, ifc.tick, last_led);
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int cm, cs, guard;
        bit cp, st, r;
`ifdef LED_PWM_EN
        ifc.brightness = 4'hF;
`endif
        // Reset, then up-count through a full wrap.
        for (int i = 0; i < 3; i++) drive(1'b1, 1, 0, 1'b0, 1'b0);
        run(257 * 16 + 4, 0, 0, 1'b0);
        // Bounce across both ends and back.
        run(16 * 16, 3, 0, 1'b0);
        // Rotate; speed raised with the prescaler at 10.
        run(11, 2, 0, 1'b0);
        run(40, 2, 2, 1'b0);
        // Pause, single steps, and a step while running.
        run(100, 2, 2, 1'b1);
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 2, 2, 1'b1, 1'b1);
            run(5, 2, 2, 1'b1);
        end
        drive(1'b0, 2, 0, 1'b0, 1'b1);
        run(20, 2, 0, 1'b0);
        // Mode change landing on an advance edge.
        guard = 0;
        while (m_el != 15 && guard < 40) begin
            drive(1'b0, 2, 0, 1'b0, 1'b0);
            guard++;
        end
        drive(1'b0, 1, 0, 1'b0, 1'b0);
        run(40, 1, 0, 1'b0);
        // Reset in the middle of a period.
        run(7, 1, 0, 1'b0);
        drive(1'b1, 1, 0, 1'b0, 1'b0);
        run(20, 1, 0, 1'b0);
        // Randomised traffic.
        cm = 1; cs = 0; cp = 1'b0;
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(199) == 0) cm = int'($urandom_range(3));
            if ($urandom_range(149) == 0) cs = int'($urandom_range(3));
            if ($urandom_range(59) == 0) cp = ~cp;
            st = ($urandom_range(7) == 0);
            r  = ($urandom_range(1499) == 0);
            if (r) cm = 1;
            drive(r, cm, cs, cp, st);
        end
        run(4, cm, cs, 1'b1);
        @(negedge clk);
        @(negedge clk);
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
